// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant/data bundle between two requesters and the arbiter.
interface bus_arbiter_if #(
    parameter int DATA_WIDTH = 14
);
    logic                  req0, req1, done0, done1;
    logic [DATA_WIDTH-1:0] d0, d1, q;
    logic                  gnt0, gnt1, sel, q_valid, timeout;
    modport master (
        output req0, req1, done0, done1, d0, d1,
        input  gnt0, gnt1, sel, q, q_valid, timeout
    );
    modport slave (
        input  req0, req1, done0, done1, d0, d1,
        output gnt0, gnt1, sel, q, q_valid, timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-requester round-robin arbiter with registered grant, select and bus word.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles when the other side is waiting.
module bus_arbiter #(
    parameter int DATA_WIDTH = 14,
    parameter int MAX_HOLD   = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
    state_t                r_state, w_next;
    logic                  r_last, r_sel, r_gnt0, r_gnt1, r_q_valid;
    logic [DATA_WIDTH-1:0] r_q;
    logic                  w_rel, w_force, w_other_req, w_sel_next;
    assign w_other_req = (r_state == GRANT0) ? bus.req1 : bus.req0;
    assign w_rel       = (r_state == GRANT0) ? (bus.done0 | ~bus.req0) : (bus.done1 | ~bus.req1);
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = (bus.req0 & bus.req1) ? (r_last ? GRANT0 : GRANT1) :
                     bus.req0 ? GRANT0 : bus.req1 ? GRANT1 : IDLE;
        else if (w_rel | w_force)
            w_next = w_other_req ? ((r_state == GRANT0) ? GRANT1 : GRANT0) : IDLE;
        w_sel_next = (w_next == IDLE) ? r_sel : (w_next == GRANT1);
    end
    // q and q_valid are loaded from next-state so data lines up with the first grant cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_sel     <= 1'b0;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_gnt0    <= (w_next == GRANT0);
            r_gnt1    <= (w_next == GRANT1);
            r_sel     <= w_sel_next;
            r_q_valid <= (w_next != IDLE);
            if (w_next != IDLE) begin
                r_q    <= w_sel_next ? bus.d1 : bus.d0;
                r_last <= w_sel_next;
            end
        end
    end
    assign bus.gnt0    = r_gnt0;
    assign bus.gnt1    = r_gnt1;
    assign bus.sel     = r_sel;
    assign bus.q       = r_q;
    assign bus.q_valid = r_q_valid;
`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] r_hold;
    logic          r_timeout;
    // r_hold counts grant cycles including the current one, saturating at MAX_HOLD
    assign w_force = (r_state != IDLE) & ~w_rel & w_other_req & (r_hold >= HW'(MAX_HOLD));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
            r_hold    <= (w_next == IDLE) ? '0 :
                         (w_next != r_state) ? HW'(1) :
                         (r_hold < HW'(MAX_HOLD)) ? r_hold + HW'(1) : r_hold;
        end
    end
    assign bus.timeout = r_timeout;
`else
    logic w_unused_max_hold;
    assign w_unused_max_hold = (MAX_HOLD != 0);
    assign w_force           = 1'b0;
    assign bus.timeout       = 1'b0;
`endif
endmodule
